// File: rtl/exmem_pipe_stage.sv
// ---------------------------------------------------------------------------
// exmem_pipe_stage
//   EX -> MEM pipeline register with a valid/ready handshake and a one-entry
//   skid buffer. Instructions leave in order with a single cycle of latency.
//   When the Memory stage stalls, the stage keeps accepting input until both
//   entries are full. Releasing the stall adds no bubble.
//
//   Predicated instructions: when condPassE is low, PCSrc, regWrite and
//   memWrite are cleared as the instruction is captured. The instruction
//   still flows through as a valid nop.
//
//   flush removes every held entry and discards the incoming instruction.
//   A forwarding tap is driven from the main register for the hazard unit.
//   A saturating counter records the number of cycles in which the Memory
//   stage stalled a valid instruction.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   inValid / inReady          Execute-side handshake (inReady is a flop)
//   aluResultE, writeDataE,
//   WA3E                       payload from Execute
//   PCSrcE, regWriteE,
//   memWriteE, memToRegE       control bits from Execute
//   condPassE                  condition flags satisfied for this instruction
//   flush                      kill all held and incoming instructions
//   outValid / outReady        Memory-side handshake
//   A, WD, WA3M                registered payload
//   PCSrcM, regWriteM,
//   memWriteM, memToRegM       registered controls, 0 while outValid is 0
//   fwdValid, fwdAddr, fwdData forwarding tap (ALU results only, no loads)
//   stallCycles                saturating count of stalled cycles
// ---------------------------------------------------------------------------
module exmem_pipe_stage #(
   parameter int ALU_W = 16,
   parameter int WD_W  = 24,
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [ALU_W-1:0] aluResultE,
   input  logic [WD_W-1:0]  writeDataE,
   input  logic [RA_W-1:0]  WA3E,
   input  logic             PCSrcE,
   input  logic             regWriteE,
   input  logic             memWriteE,
   input  logic             memToRegE,
   input  logic             condPassE,
   input  logic             flush,
   output logic             outValid,
   input  logic             outReady,
   output logic [ALU_W-1:0] A,
   output logic [WD_W-1:0]  WD,
   output logic [RA_W-1:0]  WA3M,
   output logic             PCSrcM,
   output logic             regWriteM,
   output logic             memWriteM,
   output logic             memToRegM,
   output logic             fwdValid,
   output logic [RA_W-1:0]  fwdAddr,
   output logic [ALU_W-1:0] fwdData,
   output logic [CNT_W-1:0] stallCycles
);

   typedef struct packed {
      logic [ALU_W-1:0] alu;
      logic [WD_W-1:0]  wd;
      logic [RA_W-1:0]  wa3;
      logic             pcsrc;
      logic             regwrite;
      logic             memwrite;
      logic             memtoreg;
   } entry_t;

   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   entry_t in_entry;
   logic   in_xfer;
   logic   out_xfer;

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Clear the side-effecting controls of an entry without touching its data.
   function automatic entry_t kill_ctrl(input entry_t e);
      entry_t r;
      r          = e;
      r.pcsrc    = 1'b0;
      r.regwrite = 1'b0;
      r.memwrite = 1'b0;
      r.memtoreg = 1'b0;
      return r;
   endfunction

   assign in_xfer  = inValid & in_ready_q;
   assign out_xfer = main_valid_q & outReady;

   // Capture with condition gating. memToReg is kept so that a failed load
   // still reads as a load to the forwarding logic.
   always_comb begin
      in_entry          = '0;
      in_entry.alu      = aluResultE;
      in_entry.wd       = writeDataE;
      in_entry.wa3      = WA3E;
      in_entry.pcsrc    = PCSrcE    & condPassE;
      in_entry.regwrite = regWriteE & condPassE;
      in_entry.memwrite = memWriteE & condPassE;
      in_entry.memtoreg = memToRegE;
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      stall_d      = stall_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_xfer) begin
         // Main is free this cycle. The skid entry is older, so it moves
         // into main before any new input.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            if (in_xfer) begin
               skid_d = in_entry;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (in_xfer) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end

      // Register the controls already cleared, so the outputs come straight
      // from flops and read 0 whenever no instruction is held.
      if (!main_valid_d) begin
         main_d = kill_ctrl(main_d);
      end

      in_ready_d = ~skid_valid_d;

      if (main_valid_q && !outReady) begin
         stall_d = sat_inc(stall_q);
      end
   end

   // ---- EX/MEM register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         stall_q      <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         stall_q      <= stall_d;
      end
   end

   assign inReady     = in_ready_q;
   assign outValid    = main_valid_q;
   assign A           = main_q.alu;
   assign WD          = main_q.wd;
   assign WA3M        = main_q.wa3;
   assign PCSrcM      = main_q.pcsrc;
   assign regWriteM   = main_q.regwrite;
   assign memWriteM   = main_q.memwrite;
   assign memToRegM   = main_q.memtoreg;
   assign fwdValid    = main_valid_q & main_q.regwrite & ~main_q.memtoreg;
   assign fwdAddr     = main_q.wa3;
   assign fwdData     = main_q.alu;
   assign stallCycles = stall_q;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_exmem_pipe_stage
//   Directed bench for exmem_pipe_stage. Inputs change 1 ns after each rising
//   edge, and outputs are sampled at that same point. A second instance with
//   a 4-bit stall counter shares the inputs and covers counter saturation.
// ---------------------------------------------------------------------------
module tb_exmem_pipe_stage;

   localparam int ALU_W = 16;
   localparam int WD_W  = 24;
   localparam int RA_W  = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [ALU_W-1:0] aluResultE = '0;
   logic [WD_W-1:0]  writeDataE = '0;
   logic [RA_W-1:0]  WA3E = '0;
   logic             PCSrcE = 1'b0;
   logic             regWriteE = 1'b0;
   logic             memWriteE = 1'b0;
   logic             memToRegE = 1'b0;
   logic             condPassE = 1'b1;
   logic             flush = 1'b0;
   logic             outValid;
   logic             outReady = 1'b0;
   logic [ALU_W-1:0] A;
   logic [WD_W-1:0]  WD;
   logic [RA_W-1:0]  WA3M;
   logic             PCSrcM, regWriteM, memWriteM, memToRegM;
   logic             fwdValid;
   logic [RA_W-1:0]  fwdAddr;
   logic [ALU_W-1:0] fwdData;
   logic [CNT_W-1:0] stallCycles;

   // outputs of the narrow-counter instance
   logic             inReady4, outValid4, fwdValid4;
   logic [ALU_W-1:0] A4, fwdData4;
   logic [WD_W-1:0]  WD4;
   logic [RA_W-1:0]  WA3M4, fwdAddr4;
   logic             PCSrcM4, regWriteM4, memWriteM4, memToRegM4;
   logic [3:0]       stallCycles4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   exmem_pipe_stage #(.ALU_W(ALU_W), .WD_W(WD_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .aluResultE(aluResultE), .writeDataE(writeDataE), .WA3E(WA3E),
      .PCSrcE(PCSrcE), .regWriteE(regWriteE), .memWriteE(memWriteE),
      .memToRegE(memToRegE), .condPassE(condPassE), .flush(flush),
      .outValid(outValid), .outReady(outReady), .A(A), .WD(WD), .WA3M(WA3M),
      .PCSrcM(PCSrcM), .regWriteM(regWriteM), .memWriteM(memWriteM),
      .memToRegM(memToRegM), .fwdValid(fwdValid), .fwdAddr(fwdAddr),
      .fwdData(fwdData), .stallCycles(stallCycles)
   );

   exmem_pipe_stage #(.ALU_W(ALU_W), .WD_W(WD_W), .RA_W(RA_W), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady4),
      .aluResultE(aluResultE), .writeDataE(writeDataE), .WA3E(WA3E),
      .PCSrcE(PCSrcE), .regWriteE(regWriteE), .memWriteE(memWriteE),
      .memToRegE(memToRegE), .condPassE(condPassE), .flush(flush),
      .outValid(outValid4), .outReady(outReady), .A(A4), .WD(WD4), .WA3M(WA3M4),
      .PCSrcM(PCSrcM4), .regWriteM(regWriteM4), .memWriteM(memWriteM4),
      .memToRegM(memToRegM4), .fwdValid(fwdValid4), .fwdAddr(fwdAddr4),
      .fwdData(fwdData4), .stallCycles(stallCycles4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inValid    = 1'b0;
      aluResultE = '0;
      writeDataE = '0;
      WA3E       = '0;
      PCSrcE     = 1'b0;
      regWriteE  = 1'b0;
      memWriteE  = 1'b0;
      memToRegE  = 1'b0;
      condPassE  = 1'b1;
      flush      = 1'b0;
      outReady   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL reset_outValid: got %b want 0", outValid); end
      tests++; if (inReady !== 1'b1) begin fails++; $display("FAIL reset_inReady: got %b want 1", inReady); end
      tests++; if (A !== 16'h0 || WD !== 24'h0 || WA3M !== 4'h0) begin fails++; $display("FAIL reset_payload: got A=%h WD=%h WA3M=%h want 0", A, WD, WA3M); end
      tests++; if ({PCSrcM, regWriteM, memWriteM, memToRegM, fwdValid} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {PCSrcM, regWriteM, memWriteM, memToRegM, fwdValid}); end
      tests++; if (stallCycles !== 16'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", stallCycles); end
   endtask

   task automatic test_stream();
      logic [ALU_W-1:0] vals [3];
      vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
      do_reset();
      outReady   = 1'b1;
      inValid    = 1'b1;
      aluResultE = 16'h1234;
      WA3E       = 4'd5;
      regWriteE  = 1'b1;
      condPassE  = 1'b1;
      tick();
      tests++; if (outValid !== 1'b1 || A !== 16'h1234 || WA3M !== 4'd5) begin fails++; $display("FAIL stream_first: got v=%b A=%h WA3M=%0d want 1 1234 5", outValid, A, WA3M); end
      tests++; if (fwdValid !== 1'b1 || fwdAddr !== 4'd5 || fwdData !== 16'h1234) begin fails++; $display("FAIL stream_fwd: got v=%b addr=%0d data=%h want 1 5 1234", fwdValid, fwdAddr, fwdData); end
      for (int i = 0; i < 3; i++) begin
         aluResultE = vals[i];
         WA3E       = 4'(i + 1);
         tick();
         tests++; if (outValid !== 1'b1 || A !== vals[i] || WA3M !== 4'(i + 1)) begin fails++; $display("FAIL stream_b2b%0d: got v=%b A=%h WA3M=%0d want 1 %h %0d", i, outValid, A, WA3M, vals[i], i + 1); end
      end
      inValid = 1'b0;
      tick();
      tests++; if (outValid !== 1'b0 || regWriteM !== 1'b0 || fwdValid !== 1'b0) begin fails++; $display("FAIL stream_drain: got v=%b rw=%b fwd=%b want 0 0 0", outValid, regWriteM, fwdValid); end
      tests++; if (stallCycles !== 16'd0) begin fails++; $display("FAIL stream_nostall: got %0d want 0", stallCycles); end
   endtask

   task automatic test_backpressure();
      do_reset();
      outReady   = 1'b0;
      inValid    = 1'b1;
      aluResultE = 16'h0001;
      tick();
      tests++; if (outValid !== 1'b1 || A !== 16'h0001 || inReady !== 1'b1) begin fails++; $display("FAIL bp_main: got v=%b A=%h rdy=%b want 1 0001 1", outValid, A, inReady); end
      aluResultE = 16'h0002;
      tick();
      tests++; if (inReady !== 1'b0 || A !== 16'h0001) begin fails++; $display("FAIL bp_skid: got rdy=%b A=%h want 0 0001", inReady, A); end
      aluResultE = 16'h0003;
      tick();
      tick();
      tests++; if (inReady !== 1'b0 || A !== 16'h0001 || stallCycles !== 16'd3) begin fails++; $display("FAIL bp_hold: got rdy=%b A=%h stall=%0d want 0 0001 3", inReady, A, stallCycles); end
      outReady = 1'b1;
      tick();
      tests++; if (outValid !== 1'b1 || A !== 16'h0002 || inReady !== 1'b1) begin fails++; $display("FAIL bp_rel1: got v=%b A=%h rdy=%b want 1 0002 1", outValid, A, inReady); end
      tick();
      tests++; if (outValid !== 1'b1 || A !== 16'h0003) begin fails++; $display("FAIL bp_rel2: got v=%b A=%h want 1 0003", outValid, A); end
      inValid = 1'b0;
      tick();
      tests++; if (outValid !== 1'b0 || stallCycles !== 16'd3) begin fails++; $display("FAIL bp_end: got v=%b stall=%0d want 0 3", outValid, stallCycles); end
   endtask

   task automatic test_cond_fail();
      do_reset();
      outReady   = 1'b1;
      inValid    = 1'b1;
      aluResultE = 16'hBEEF;
      writeDataE = 24'hABCDEF;
      WA3E       = 4'd9;
      PCSrcE     = 1'b1;
      regWriteE  = 1'b1;
      memWriteE  = 1'b1;
      condPassE  = 1'b0;
      tick();
      tests++; if (outValid !== 1'b1 || {PCSrcM, regWriteM, memWriteM, fwdValid} !== 4'b0000) begin fails++; $display("FAIL cond_gate: got v=%b ctrl=%b want 1 0000", outValid, {PCSrcM, regWriteM, memWriteM, fwdValid}); end
      tests++; if (A !== 16'hBEEF || WD !== 24'hABCDEF || WA3M !== 4'd9) begin fails++; $display("FAIL cond_data: got A=%h WD=%h WA3M=%0d want BEEF ABCDEF 9", A, WD, WA3M); end
      condPassE = 1'b1;
      tick();
      tests++; if ({PCSrcM, regWriteM, memWriteM, fwdValid} !== 4'b1111) begin fails++; $display("FAIL cond_pass: got ctrl=%b want 1111", {PCSrcM, regWriteM, memWriteM, fwdValid}); end
   endtask

   task automatic test_flush();
      do_reset();
      outReady   = 1'b0;
      inValid    = 1'b1;
      PCSrcE     = 1'b1;
      regWriteE  = 1'b1;
      memWriteE  = 1'b1;
      aluResultE = 16'h00A1;
      tick();
      aluResultE = 16'h00A2;
      tick();
      tests++; if (inReady !== 1'b0 || outValid !== 1'b1) begin fails++; $display("FAIL flush_setup: got rdy=%b v=%b want 0 1", inReady, outValid); end
      aluResultE = 16'h00A3;
      flush      = 1'b1;
      tick();
      tests++; if (outValid !== 1'b0 || inReady !== 1'b1) begin fails++; $display("FAIL flush_state: got v=%b rdy=%b want 0 1", outValid, inReady); end
      tests++; if ({PCSrcM, regWriteM, memWriteM, memToRegM, fwdValid} !== 5'b0) begin fails++; $display("FAIL flush_ctrl: got %b want 00000", {PCSrcM, regWriteM, memWriteM, memToRegM, fwdValid}); end
      flush    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL flush_no_emerge%0d: got v=%b A=%h want 0", i, outValid, A); end
      end
      // flush while main is full and an input is accepted on the same edge
      inValid    = 1'b1;
      outReady   = 1'b0;
      aluResultE = 16'h00B1;
      tick();
      aluResultE = 16'h00B2;
      flush      = 1'b1;
      tick();
      flush   = 1'b0;
      inValid = 1'b0;
      outReady = 1'b1;
      tick();
      tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL flush_discard_in: got v=%b A=%h want 0", outValid, A); end
   endtask

   task automatic test_load_fwd();
      do_reset();
      outReady   = 1'b1;
      inValid    = 1'b1;
      WA3E       = 4'd3;
      regWriteE  = 1'b1;
      memToRegE  = 1'b1;
      aluResultE = 16'h0400;
      tick();
      tests++; if (outValid !== 1'b1 || regWriteM !== 1'b1 || memToRegM !== 1'b1 || fwdValid !== 1'b0) begin fails++; $display("FAIL load_fwd: got v=%b rw=%b m2r=%b fwd=%b want 1 1 1 0", outValid, regWriteM, memToRegM, fwdValid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      outReady   = 1'b0;
      inValid    = 1'b1;
      regWriteE  = 1'b1;
      WA3E       = 4'd7;
      aluResultE = 16'h0C01;
      tick();
      aluResultE = 16'h0C02;
      tick();
      inValid = 1'b0;
      repeat (6) tick();
      tests++; if (stallCycles !== 16'd7 || inReady !== 1'b0) begin fails++; $display("FAIL areset_setup: got stall=%0d rdy=%b want 7 0", stallCycles, inReady); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (outValid !== 1'b0 || stallCycles !== 16'd0 || A !== 16'h0 || WA3M !== 4'h0 || regWriteM !== 1'b0) begin fails++; $display("FAIL areset_now: got v=%b stall=%0d A=%h WA3M=%0d rw=%b want all 0", outValid, stallCycles, A, WA3M, regWriteM); end
      #2;
      rst_n    = 1'b1;
      outReady = 1'b1;
      tick();
      tests++; if (outValid !== 1'b0 || inReady !== 1'b1) begin fails++; $display("FAIL areset_skid_cleared: got v=%b rdy=%b A=%h want 0 1", outValid, inReady, A); end
   endtask

   task automatic test_saturation();
      do_reset();
      outReady   = 1'b0;
      inValid    = 1'b1;
      aluResultE = 16'h0055;
      tick();
      inValid = 1'b0;
      repeat (20) tick();
      tests++; if (stallCycles4 !== 4'd15) begin fails++; $display("FAIL sat_cnt4: got %0d want 15", stallCycles4); end
      tests++; if (stallCycles !== 16'd20) begin fails++; $display("FAIL sat_cnt16: got %0d want 20", stallCycles); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_cond_fail();
      test_flush();
      test_load_fwd();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
